// File: rtl/cache_write_merge_pkg.sv
// Shared types for the write-combining buffer: FSM states and default-size
// cache line, offset and byte-mask types.
package cache_write_merge_pkg;

    localparam int DEF_WORD_BYTES = 2;
    localparam int DEF_LINE_WORDS = 8;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_LINE_BYTES = DEF_WORD_BYTES * DEF_LINE_WORDS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        DRAIN = 2'd2
    } cwm_state_e;

    typedef logic [8*DEF_LINE_BYTES-1:0]         cache_line_t;
    typedef logic [$clog2(DEF_LINE_BYTES)-1:0]   cache_offset_t;
    typedef logic [DEF_WORD_BYTES-1:0]           cache_wmask_t;
    typedef logic [DEF_LINE_BYTES-1:0]           line_bmask_t;

    // Bit width able to hold v-1, never below one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/cache_write_merge_if.sv
// CPU write channel, cache drain channel and status of the write-combining buffer.
interface cache_write_merge_if #(
    parameter int WORD_BYTES = 2,
    parameter int LINE_WORDS = 8,
    parameter int ADDR_WIDTH = 16
);
    localparam int LINE_BYTES = WORD_BYTES * LINE_WORDS;

    logic                    wr_valid;
    logic                    wr_ready;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [8*WORD_BYTES-1:0] wr_data;
    logic [WORD_BYTES-1:0]   wr_wmask;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [ADDR_WIDTH-1:0]   out_addr;
    logic [8*LINE_BYTES-1:0] out_line;
    logic [LINE_BYTES-1:0]   out_bmask;
    logic                    empty;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_wmask, flush, out_ready,
        input  wr_ready, out_valid, out_addr, out_line, out_bmask, empty
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_wmask, flush, out_ready,
        output wr_ready, out_valid, out_addr, out_line, out_bmask, empty
    );

endinterface

// File: rtl/cache_write_merge_line_byte_merge.sv
// Combinational per-byte merge of one byte-masked word into a cache line;
// also reports which line bytes were selected.
module line_byte_merge
    import cache_write_merge_pkg::*;
#(
    parameter int WORD_BYTES = DEF_WORD_BYTES,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    localparam int LINE_BYTES = WORD_BYTES * LINE_WORDS,
    localparam int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic [8*LINE_BYTES-1:0] i_line,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic [8*WORD_BYTES-1:0] i_data,
    input  logic [WORD_BYTES-1:0]   i_wmask,
    output logic [8*LINE_BYTES-1:0] o_line,
    output logic [LINE_BYTES-1:0]   o_sel
);

    for (genvar b = 0; b < LINE_BYTES; b++) begin : g_byte
        localparam int WORD = b / WORD_BYTES;
        localparam int LANE = b % WORD_BYTES;

        assign o_sel[b]        = (i_idx == IDX_W'(WORD)) && i_wmask[LANE];
        assign o_line[8*b +: 8] = o_sel[b] ? i_data[8*LANE +: 8] : i_line[8*b +: 8];
    end

endmodule

// File: rtl/cache_write_merge.sv
// Single-line write-combining buffer: merges byte-masked word writes into one
// line and drains it to the cache on flush, line change or idle timeout.
module cache_write_merge
    import cache_write_merge_pkg::*;
#(
    parameter int WORD_BYTES = DEF_WORD_BYTES,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = 15
) (
    input logic clk,
    input logic rst,
    cache_write_merge_if.slave bus
);

    localparam int LINE_BYTES = WORD_BYTES * LINE_WORDS;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int WB_W       = $clog2(WORD_BYTES);
    localparam int IDX_W      = OFF_W - WB_W;
    localparam int TAG_W      = ADDR_WIDTH - OFF_W;
    localparam int TMR_W      = clog2_min1(TIMEOUT + 1);
    localparam int TMO_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TMR_W-1:0] TMR_MAX = {TMR_W{1'b1}};

    cwm_state_e              r_state, w_state_nxt;
    logic [8*LINE_BYTES-1:0] r_line,  w_line_nxt;
    logic [LINE_BYTES-1:0]   r_bmask, w_bmask_nxt;
    logic [TAG_W-1:0]        r_tag,   w_tag_nxt;
    logic [TMR_W-1:0]        r_timer, w_timer_nxt;

    logic                    w_wr_ready;
    logic                    w_out_valid;
    logic [TAG_W-1:0]        w_tag;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_tag_hit;
    logic [8*LINE_BYTES-1:0] w_merged;
    logic [LINE_BYTES-1:0]   w_sel;

    assign w_tag     = bus.wr_addr[ADDR_WIDTH-1:OFF_W];
    assign w_idx     = bus.wr_addr[OFF_W-1:WB_W];
    assign w_tag_hit = (w_tag == r_tag);

    if (WB_W > 0) begin : g_lo
        logic w_unused_lo;
        assign w_unused_lo = ^bus.wr_addr[WB_W-1:0];
    end

    line_byte_merge #(
        .WORD_BYTES (WORD_BYTES),
        .LINE_WORDS (LINE_WORDS)
    ) u_merge (
        .i_line  (r_line),
        .i_idx   (w_idx),
        .i_data  (bus.wr_data),
        .i_wmask (bus.wr_wmask),
        .o_line  (w_merged),
        .o_sel   (w_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // A hit write merges even when the same cycle triggers a drain, so its
    // bytes travel with the drained line.
    always_comb begin
        w_state_nxt = r_state;
        w_line_nxt  = r_line;
        w_bmask_nxt = r_bmask;
        w_tag_nxt   = r_tag;
        w_timer_nxt = r_timer;
        w_wr_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_wr_ready = 1'b1;
                if (bus.wr_valid && (|bus.wr_wmask)) begin
                    w_tag_nxt   = w_tag;
                    w_line_nxt  = w_merged;
                    w_bmask_nxt = w_sel;
                    w_timer_nxt = '0;
                    w_state_nxt = MERGE;
                end
            end
            MERGE: begin
                w_wr_ready = w_tag_hit;
                if (bus.wr_valid && w_tag_hit) begin
                    w_line_nxt  = w_merged;
                    w_bmask_nxt = r_bmask | w_sel;
                    w_timer_nxt = '0;
                end else if (r_timer != TMR_MAX) begin
                    w_timer_nxt = r_timer + 1'b1;
                end
                if (bus.wr_valid && !w_tag_hit) begin
                    w_state_nxt = DRAIN;
                end else if (bus.flush) begin
                    w_state_nxt = DRAIN;
                end else if ((TIMEOUT != 0) && !bus.wr_valid && (r_timer == TMR_W'(TMO_LAST))) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_bmask_nxt = '0;
                    w_timer_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line  <= '0;
            r_bmask <= '0;
            r_tag   <= '0;
            r_timer <= '0;
        end else begin
            r_line  <= w_line_nxt;
            r_bmask <= w_bmask_nxt;
            r_tag   <= w_tag_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_addr  = {r_tag, {OFF_W{1'b0}}};
    assign bus.out_line  = r_line;
    assign bus.out_bmask = r_bmask;
    assign bus.empty     = (r_state == IDLE);

endmodule

// File: tb/tb_cache_write_merge.sv
// Directed bench for the write-combining buffer: one instance with a 4-cycle
// idle timeout and one with the timer disabled.
module tb_cache_write_merge;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    cache_write_merge_if #(.WORD_BYTES(2), .LINE_WORDS(8), .ADDR_WIDTH(16)) bus_a ();
    cache_write_merge_if #(.WORD_BYTES(2), .LINE_WORDS(8), .ADDR_WIDTH(16)) bus_b ();

    cache_write_merge #(
        .WORD_BYTES (2), .LINE_WORDS (8), .ADDR_WIDTH (16), .TIMEOUT (4)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    cache_write_merge #(
        .WORD_BYTES (2), .LINE_WORDS (8), .ADDR_WIDTH (16), .TIMEOUT (0)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr_a(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] mask);
        bus_a.wr_valid = 1'b1;
        bus_a.wr_addr  = addr;
        bus_a.wr_data  = data;
        bus_a.wr_wmask = mask;
        step();
        bus_a.wr_valid = 1'b0;
        bus_a.wr_wmask = 2'b00;
    endtask

    task automatic flush_a();
        bus_a.flush = 1'b1;
        step();
        bus_a.flush = 1'b0;
    endtask

    task automatic drain_a();
        bus_a.out_ready = 1'b1;
        step();
        bus_a.out_ready = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        bus_a.wr_valid = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.wr_wmask = '0;
        bus_a.flush = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.wr_valid = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.wr_wmask = '0;
        bus_b.flush = 1'b0; bus_b.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // reset state
        chk("rst_valid", 128'(bus_a.out_valid), 128'(1'b0));
        chk("rst_empty", 128'(bus_a.empty), 128'(1'b1));
        chk("rst_line",  128'(bus_a.out_line), 128'h0);
        chk("rst_bmask", 128'(bus_a.out_bmask), 128'h0);
        chk("rst_addr",  128'(bus_a.out_addr), 128'h0);
        chk("rst_wrrdy", 128'(bus_a.wr_ready), 128'(1'b1));

        // zero-mask write in IDLE is a no-op
        wr_a(16'h4000, 16'hFFFF, 2'b00);
        chk("nomask_empty", 128'(bus_a.empty), 128'(1'b1));

        // single write + flush
        wr_a(16'h1234, 16'hBEEF, 2'b11);
        chk("t1_empty", 128'(bus_a.empty), 128'(1'b0));
        chk("t1_bmask_pre", 128'(bus_a.out_bmask), 128'h0030);
        chk("t1_novalid", 128'(bus_a.out_valid), 128'(1'b0));
        flush_a();
        chk("t1_valid", 128'(bus_a.out_valid), 128'(1'b1));
        chk("t1_addr",  128'(bus_a.out_addr), 128'h1230);
        chk("t1_line",  128'(bus_a.out_line), 128'h0000_0000_0000_0000_0000_BEEF_0000_0000);
        chk("t1_bmask", 128'(bus_a.out_bmask), 128'h0030);
        chk("t1_wrrdy", 128'(bus_a.wr_ready), 128'(1'b0));
        drain_a();
        chk("t1_idle",  128'(bus_a.empty), 128'(1'b1));
        chk("t1_vdrop", 128'(bus_a.out_valid), 128'(1'b0));
        chk("t1_bclr",  128'(bus_a.out_bmask), 128'h0);

        // merge three writes into one line
        wr_a(16'h1230, 16'h0011, 2'b01);
        wr_a(16'h1230, 16'h2200, 2'b10);
        wr_a(16'h123E, 16'hCAFE, 2'b11);
        flush_a();
        chk("t2_valid", 128'(bus_a.out_valid), 128'(1'b1));
        chk("t2_b0",  128'(bus_a.out_line[7:0]), 128'h11);
        chk("t2_b1",  128'(bus_a.out_line[15:8]), 128'h22);
        chk("t2_b14", 128'(bus_a.out_line[119:112]), 128'hFE);
        chk("t2_b15", 128'(bus_a.out_line[127:120]), 128'hCA);
        chk("t2_bmask", 128'(bus_a.out_bmask), 128'hC003);
        drain_a();

        // tag mismatch forces a drain, then the new write lands in IDLE
        wr_a(16'h1230, 16'h0102, 2'b11);
        bus_a.wr_valid = 1'b1;
        bus_a.wr_addr  = 16'h5670;
        bus_a.wr_data  = 16'hA5A5;
        bus_a.wr_wmask = 2'b11;
        #1;
        chk("t3_wrrdy_miss", 128'(bus_a.wr_ready), 128'(1'b0));
        step();
        chk("t3_valid", 128'(bus_a.out_valid), 128'(1'b1));
        chk("t3_addr",  128'(bus_a.out_addr), 128'h1230);
        chk("t3_bmask", 128'(bus_a.out_bmask), 128'h0003);
        chk("t3_wrrdy_drain", 128'(bus_a.wr_ready), 128'(1'b0));
        bus_a.out_ready = 1'b1;
        step();
        bus_a.out_ready = 1'b0;
        chk("t3_idle", 128'(bus_a.empty), 128'(1'b1));
        chk("t3_wrrdy_idle", 128'(bus_a.wr_ready), 128'(1'b1));
        step();
        bus_a.wr_valid = 1'b0;
        bus_a.wr_wmask = 2'b00;
        chk("t3_newempty", 128'(bus_a.empty), 128'(1'b0));
        chk("t3_newaddr",  128'(bus_a.out_addr), 128'h5670);
        chk("t3_newbmask", 128'(bus_a.out_bmask), 128'h0003);
        chk("t3_newdata",  128'(bus_a.out_line[15:0]), 128'hA5A5);
        flush_a();
        chk("t3_newdrain", 128'(bus_a.out_valid), 128'(1'b1));
        drain_a();

        // backpressure: line held, flush and hit writes ignored in DRAIN
        wr_a(16'h2002, 16'h7788, 2'b10);
        flush_a();
        bus_a.flush    = 1'b1;
        bus_a.wr_valid = 1'b1;
        bus_a.wr_addr  = 16'h2000;
        bus_a.wr_data  = 16'h9999;
        bus_a.wr_wmask = 2'b11;
        for (int k = 0; k < 5; k++) begin
            chk("t4_valid", 128'(bus_a.out_valid), 128'(1'b1));
            chk("t4_addr",  128'(bus_a.out_addr), 128'h2000);
            chk("t4_byte3", 128'(bus_a.out_line[31:24]), 128'h77);
            chk("t4_bmask", 128'(bus_a.out_bmask), 128'h0008);
            chk("t4_wrrdy", 128'(bus_a.wr_ready), 128'(1'b0));
            step();
        end
        bus_a.flush    = 1'b0;
        bus_a.wr_valid = 1'b0;
        bus_a.wr_wmask = 2'b00;
        chk("t4_byte3_end", 128'(bus_a.out_line[31:24]), 128'h77);
        drain_a();
        chk("t4_idle", 128'(bus_a.empty), 128'(1'b1));

        // idle timeout: drain after the 4th edge following acceptance
        wr_a(16'h3000, 16'h0001, 2'b01);
        for (int k = 1; k <= 3; k++) begin
            chk("t5_wait", 128'(bus_a.out_valid), 128'(1'b0));
            step();
        end
        chk("t5_wait3", 128'(bus_a.out_valid), 128'(1'b0));
        step();
        chk("t5_tmo", 128'(bus_a.out_valid), 128'(1'b1));
        drain_a();

        // hit write on idle cycle 3 restarts the count
        wr_a(16'h3000, 16'h0001, 2'b01);
        step();
        step();
        wr_a(16'h3002, 16'h0200, 2'b10);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("t5_restart_wait", 128'(bus_a.out_valid), 128'(1'b0));
        end
        step();
        chk("t5_restart_tmo", 128'(bus_a.out_valid), 128'(1'b1));
        chk("t5_restart_bmask", 128'(bus_a.out_bmask), 128'h0009);
        drain_a();

        // flush with a simultaneous hit write, then reset during DRAIN
        wr_a(16'h1238, 16'h5566, 2'b11);
        bus_a.flush    = 1'b1;
        bus_a.wr_valid = 1'b1;
        bus_a.wr_addr  = 16'h1232;
        bus_a.wr_data  = 16'h3344;
        bus_a.wr_wmask = 2'b11;
        step();
        bus_a.flush    = 1'b0;
        bus_a.wr_valid = 1'b0;
        bus_a.wr_wmask = 2'b00;
        chk("t6_valid", 128'(bus_a.out_valid), 128'(1'b1));
        chk("t6_b2", 128'(bus_a.out_line[23:16]), 128'h44);
        chk("t6_b3", 128'(bus_a.out_line[31:24]), 128'h33);
        chk("t6_bmask", 128'(bus_a.out_bmask), 128'h030C);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_valid", 128'(bus_a.out_valid), 128'(1'b0));
        chk("t6_rst_empty", 128'(bus_a.empty), 128'(1'b1));
        chk("t6_rst_bmask", 128'(bus_a.out_bmask), 128'h0);
        chk("t6_rst_line",  128'(bus_a.out_line), 128'h0);

        // TIMEOUT=0: no auto-drain
        bus_b.wr_valid = 1'b1;
        bus_b.wr_addr  = 16'h1000;
        bus_b.wr_data  = 16'hABCD;
        bus_b.wr_wmask = 2'b11;
        step();
        bus_b.wr_valid = 1'b0;
        bus_b.wr_wmask = 2'b00;
        for (int k = 0; k < 100; k++) step();
        chk("t7_novalid", 128'(bus_b.out_valid), 128'(1'b0));
        chk("t7_notempty", 128'(bus_b.empty), 128'(1'b0));
        chk("t7_bmask", 128'(bus_b.out_bmask), 128'h0003);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
